phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 21 ++
 rtl/phase_window_cmp.sv | 22 ++
 rtl/phase_sequencer.sv | 137 +++++++++++++
 tb/tb_phase_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// phase_sequencer_pkg
// Shared definitions for the phase sequencer:
//   - state_e : 1-bit sequencer state encoding (IDLE / RUN)
//   - DEF_*   : default window and period constants for the two-channel setup
//                (channel 0 window [0,11), channel 1 window [23,35), last = 47)
// -----------------------------------------------------------------------------
package phase_sequencer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int DEF_ON0  = 0;
   localparam int DEF_OFF0 = 11;
   localparam int DEF_ON1  = 23;
   localparam int DEF_OFF1 = 35;
   localparam int DEF_LAST = 47;

endpackage

// File: rtl/phase_window_cmp.sv
// -----------------------------------------------------------------------------
// phase_window_cmp
// Unsigned half-open window test: hit_o = (on_i <= x_i < off_i).
// An empty window (on_i >= off_i) never hits.
// Ports:
//   on_i  [CW]  window start (inclusive)
//   off_i [CW]  window end (exclusive)
//   x_i   [CW]  position under test
//   hit_o       1 when x_i lies inside the window
// -----------------------------------------------------------------------------
module phase_window_cmp #(
   parameter int CW = 6
) (
   input  logic [CW-1:0] on_i,
   input  logic [CW-1:0] off_i,
   input  logic [CW-1:0] x_i,
   output logic          hit_o
);

   assign hit_o = (x_i >= on_i) && (x_i < off_i);

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Runs a counter over a period of last+1 cycles, either once (mode=0) or
// repeatedly until a graceful stop (mode=1), and drives one registered phase
// enable per channel while the count sits inside that channel's window.
// Ports:
//   clk              clock, all state on the rising edge
//   reset            synchronous active-high reset
//   start            begin a sequence (only honoured while idle)
//   mode             0 = one-shot, 1 = continuous; latched at start
//   stop             finish the current period, then go idle
//   last    [CW]     terminal count; latched at start
//   win_on  [NCH*CW] per-channel window start, channel i at [i*CW +: CW]
//   win_off [NCH*CW] per-channel window end (exclusive), same packing
//   ph_out  [NCH]    registered phase enables
//   count   [CW]     position within the period (0 while idle)
//   busy             high while running
//   wrap             high on the count==last cycle
//   done             one-cycle pulse on the first idle cycle after a sequence
// -----------------------------------------------------------------------------
module phase_sequencer
   import phase_sequencer_pkg::*;
#(
   parameter int NCH = 2,
   parameter int CW  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic              stop,
   input  logic [CW-1:0]     last,
   input  logic [NCH*CW-1:0] win_on,
   input  logic [NCH*CW-1:0] win_off,
   output logic [NCH-1:0]    ph_out,
   output logic [CW-1:0]     count,
   output logic              busy,
   output logic              wrap,
   output logic              done
);

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [NCH-1:0]    ph_q, ph_d;
   logic              stop_pend_q, stop_pend_d;
   logic              done_q, done_d;
   logic              mode_q, mode_d;
   logic [CW-1:0]     last_q, last_d;
   logic [NCH*CW-1:0] on_q, on_d;
   logic [NCH*CW-1:0] off_q, off_d;
   logic [NCH-1:0]    hit;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
      state_d     = state_q;
      count_d     = count_q;
      stop_pend_d = stop_pend_q;
      done_d      = 1'b0;
      mode_d      = mode_q;
      last_d      = last_q;
      on_d        = on_q;
      off_d       = off_q;

      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d     = ST_RUN;
            count_d     = '0;
            stop_pend_d = 1'b0;
            mode_d      = mode;
            last_d      = last;
            on_d        = win_on;
            off_d       = win_off;
         end
      end else begin
         if (count_q == last_q) begin
            // A stop arriving on the terminal cycle itself still ends here.
            if (mode_q && !stop_pend_q && !stop) begin
               count_d = '0;
            end else begin
               state_d     = ST_IDLE;
               count_d     = '0;
               stop_pend_d = 1'b0;
               done_d      = 1'b1;
            end
         end else begin
            count_d     = count_q + CW'(1);
            stop_pend_d = stop_pend_q | stop;
         end
      end
   end

   // Windows are evaluated against next-state count and config so that
   // ph_out moves on the same edge as count, including the start edge.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
      phase_window_cmp #(.CW(CW)) u_cmp (
         .on_i  (on_d[gi*CW +: CW]),
         .off_i (off_d[gi*CW +: CW]),
         .x_i   (count_d),
         .hit_o (hit[gi])
      );
   end

   assign ph_d = (state_d == ST_RUN) ? hit : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the latched config is a handful of flops, not a memory, so it is reset with everything else.
         state_q     <= ST_IDLE;
         count_q     <= '0;
         ph_q        <= '0;
         stop_pend_q <= 1'b0;
         done_q      <= 1'b0;
         mode_q      <= 1'b0;
         last_q      <= '0;
         on_q        <= '0;
         off_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state_q     <= state_d;
         count_q     <= count_d;
         ph_q        <= ph_d;
         stop_pend_q <= stop_pend_d;
         done_q      <= done_d;
         mode_q      <= mode_d;
         last_q      <= last_d;
         on_q        <= on_d;
         off_q       <= off_d;
      end
   end

   assign ph_out = ph_q;
   assign count  = count_q;
   assign busy   = (state_q == ST_RUN);
   assign wrap   = (state_q == ST_RUN) && (count_q == last_q);
   assign done   = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Self-checking bench for phase_sequencer (NCH=2, CW=6). Directed scenarios
// check against values worked out from the sequencing rules; a randomized run
// checks every cycle against a behavioural model (integer position, running
// flag, pending-stop flag) updated on each rising edge.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;
   import phase_sequencer_pkg::*;

   localparam int NCH = 2;
   localparam int CW  = 6;

   logic              clk = 1'b0;
   logic              reset, start, mode, stop;
   logic [CW-1:0]     last;
   logic [NCH*CW-1:0] win_on, win_off;
   logic [NCH-1:0]    ph_out;
   logic [CW-1:0]     count;
   logic              busy, wrap, done;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   bit m_run, m_stop, m_done, m_mode;
   int m_pos, m_last;
   int m_on[NCH];
   int m_off[NCH];

   phase_sequencer #(.NCH(NCH), .CW(CW)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mode    (mode),
      .stop    (stop),
      .last    (last),
      .win_on  (win_on),
      .win_off (win_off),
      .ph_out  (ph_out),
      .count   (count),
      .busy    (busy),
      .wrap    (wrap),
      .done    (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_step();
      if (reset) begin
         m_run = 0; m_pos = 0; m_stop = 0; m_done = 0; m_mode = 0; m_last = 0;
         for (int i = 0; i < NCH; i++) begin m_on[i] = 0; m_off[i] = 0; end
      end else if (!m_run) begin
         m_done = 0;
         if (start) begin
            m_run = 1; m_pos = 0; m_stop = 0; m_mode = mode; m_last = int'(last);
            for (int i = 0; i < NCH; i++) begin
               m_on[i]  = int'(win_on[i*CW +: CW]);
               m_off[i] = int'(win_off[i*CW +: CW]);
            end
         end
      end else begin
         m_done = 0;
         if (m_pos == m_last) begin
            if (m_mode && !m_stop && !stop) m_pos = 0;
            else begin m_run = 0; m_pos = 0; m_done = 1; m_stop = 0; end
         end else begin
            m_pos++;
            if (stop) m_stop = 1;
         end
      end
   endtask

   // one clock: inputs are sampled at the edge, outputs are settled 1 ns later
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1; start = 0; stop = 0;
      tick();
      reset = 0;
   endtask

   task automatic set_cfg(input bit md, input int l, input int on0, input int off0,
                          input int on1, input int off1);
      mode    = md;
      last    = CW'(l);
      win_on  = {CW'(on1), CW'(on0)};
      win_off = {CW'(off1), CW'(off0)};
   endtask

   task automatic test_reset();
      reset = 1; start = 1; stop = 1;
      set_cfg(1, DEF_LAST, DEF_ON0, DEF_OFF0, DEF_ON1, DEF_OFF1);
      tick();
      tick();
      total++;
      if ({ph_out, count, busy, wrap, done} !== '0) begin
         bad++;
         $display("FAIL reset_state got ph=%b cnt=%0d busy=%b wrap=%b done=%b want all 0",
                  ph_out, count, busy, wrap, done);
      end
      reset = 0; start = 0; stop = 0;
   endtask

   task automatic test_oneshot();
      int cyc;
      logic [1:0] exp_ph;
      do_reset();
      set_cfg(0, DEF_LAST, DEF_ON0, DEF_OFF0, DEF_ON1, DEF_OFF1);
      start = 1; tick(); start = 0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         exp_ph = {(cyc >= 23 && cyc <= 34), (cyc <= 10)};
         total++;
         if (count !== CW'(cyc)) begin
            bad++; $display("FAIL oneshot_count got=%0d want=%0d", count, cyc);
         end
         total++;
         if (ph_out !== exp_ph) begin
            bad++; $display("FAIL oneshot_ph at %0d got=%b want=%b", cyc, ph_out, exp_ph);
         end
         total++;
         if (wrap !== (cyc == 47) || done !== 1'b0) begin
            bad++; $display("FAIL oneshot_wrap at %0d got wrap=%b done=%b", cyc, wrap, done);
         end
         cyc++;
         tick();
      end
      total++;
      if (cyc != 48) begin
         bad++; $display("FAIL oneshot_busy_len got=%0d want=48", cyc);
      end
      total++;
      if (done !== 1'b1 || ph_out !== 2'b00) begin
         bad++; $display("FAIL oneshot_done got done=%b ph=%b want done=1 ph=00", done, ph_out);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL oneshot_done_pulse got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_stop();
      int cyc, wraps, dones, last_cnt;
      do_reset();
      set_cfg(1, DEF_LAST, DEF_ON0, DEF_OFF0, DEF_ON1, DEF_OFF1);
      start = 1; tick(); start = 0;
      cyc = 0; wraps = 0; dones = 0; last_cnt = -1;
      while (busy === 1'b1 && cyc < 400) begin
         if (wrap === 1'b1) wraps++;
         if (done === 1'b1) dones++;
         stop = (wraps == 2 && count == 6'd30);
         last_cnt = int'(count);
         cyc++;
         tick();
      end
      stop = 0;
      total++;
      if (wraps != 3) begin
         bad++; $display("FAIL stop_wraps got=%0d want=3", wraps);
      end
      total++;
      if (cyc != 144 || last_cnt != 47) begin
         bad++; $display("FAIL stop_length got cycles=%0d last_count=%0d want 144 47", cyc, last_cnt);
      end
      total++;
      if (dones != 0 || done !== 1'b1) begin
         bad++; $display("FAIL stop_done got early=%0d now=%b want 0 1", dones, done);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL stop_idle got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_never();
      int cyc;
      do_reset();
      set_cfg(0, DEF_LAST, 5, 5, 50, 60);
      start = 1; tick(); start = 0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         total++;
         if (ph_out !== 2'b00) begin
            bad++; $display("FAIL never_ph at %0d got=%b want=00", cyc, ph_out);
         end
         cyc++;
         tick();
      end
      total++;
      if (cyc != 48 || done !== 1'b1) begin
         bad++; $display("FAIL never_len got cycles=%0d done=%b want 48 1", cyc, done);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      do_reset();
      set_cfg(0, DEF_LAST, DEF_ON0, DEF_OFF0, DEF_ON1, DEF_OFF1);
      start = 1; tick(); start = 0;
      cyc = 0;
      while (count !== 6'd20 && cyc < 60) begin cyc++; tick(); end
      total++;
      if (count !== 6'd20 || busy !== 1'b1) begin
         bad++; $display("FAIL rstmid_reach got cnt=%0d busy=%b want 20 1", count, busy);
      end
      reset = 1; tick(); reset = 0;
      total++;
      if ({ph_out, count, busy, wrap, done} !== '0) begin
         bad++; $display("FAIL rstmid_clear got ph=%b cnt=%0d busy=%b wrap=%b done=%b want all 0",
                         ph_out, count, busy, wrap, done);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_nodone got done=%b busy=%b want 0 0", done, busy);
         end
      end
      start = 1; tick(); start = 0;
      total++;
      if (busy !== 1'b1 || count !== 6'd0 || ph_out !== 2'b01) begin
         bad++; $display("FAIL rstmid_restart got busy=%b cnt=%0d ph=%b want 1 0 01", busy, count, ph_out);
      end
      tick();
      total++;
      if (count !== 6'd1) begin
         bad++; $display("FAIL rstmid_count got=%0d want=1", count);
      end
   endtask

   task automatic test_back_to_back();
      int p;
      logic [1:0] exp_ph;
      do_reset();
      set_cfg(0, 3, 0, 2, 2, 4);
      start = 1;
      tick();
      for (int i = 0; i < 15; i++) begin
         p = i % 5;
         exp_ph = (p < 4) ? {(p >= 2), (p < 2)} : 2'b00;
         total++;
         if (busy !== (p < 4) || count !== CW'((p < 4) ? p : 0) || done !== (p == 4) ||
             wrap !== (p == 3) || ph_out !== exp_ph) begin
            bad++;
            $display("FAIL b2b step %0d got busy=%b cnt=%0d done=%b wrap=%b ph=%b want busy=%b cnt=%0d done=%b wrap=%b ph=%b",
                     i, busy, count, done, wrap, ph_out, (p < 4), (p < 4) ? p : 0, (p == 4), (p == 3), exp_ph);
         end
         tick();
      end
      start = 0;
      for (int i = 0; i < 6; i++) tick();
   endtask

   task automatic test_last0();
      do_reset();
      set_cfg(0, 0, 0, 1, 0, 0);
      start = 1; tick(); start = 0;
      total++;
      if (busy !== 1'b1 || count !== 6'd0 || ph_out !== 2'b01 || wrap !== 1'b1 || done !== 1'b0) begin
         bad++; $display("FAIL last0_run got busy=%b cnt=%0d ph=%b wrap=%b done=%b want 1 0 01 1 0",
                         busy, count, ph_out, wrap, done);
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b1 || ph_out !== 2'b00 || wrap !== 1'b0) begin
         bad++; $display("FAIL last0_done got busy=%b done=%b ph=%b wrap=%b want 0 1 00 0",
                         busy, done, ph_out, wrap);
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++; $display("FAIL last0_pulse got done=%b want 0", done);
      end
   endtask

   task automatic test_random();
      int l;
      logic [CW-1:0]  exp_count;
      logic [NCH-1:0] exp_ph;
      bit exp_wrap;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
         set_cfg(1'($urandom_range(0, 1)), l,
                 int'($urandom_range(0, 63)) % (l + 4), int'($urandom_range(0, 63)) % (l + 4),
                 int'($urandom_range(0, 63)) % (l + 4), int'($urandom_range(0, 63)) % (l + 4));
         tick();
         exp_count = m_run ? CW'(m_pos) : '0;
         exp_wrap  = m_run && (m_pos == m_last);
         for (int i = 0; i < NCH; i++)
            exp_ph[i] = m_run && (m_on[i] <= m_pos) && (m_pos < m_off[i]);
         total++;
         if (ph_out !== exp_ph || count !== exp_count || busy !== m_run ||
             wrap !== exp_wrap || done !== m_done) begin
            bad++;
            $display("FAIL random cyc=%0d got ph=%b cnt=%0d busy=%b wrap=%b done=%b want ph=%b cnt=%0d busy=%b wrap=%b done=%b",
                     c, ph_out, count, busy, wrap, done, exp_ph, exp_count, m_run, exp_wrap, m_done);
         end
      end
      reset = 0; start = 0; stop = 0;
   endtask

   initial begin
      reset = 1; start = 0; stop = 0;
      set_cfg(0, 0, 0, 0, 0, 0);
      test_reset();
      test_oneshot();
      test_stop();
      test_never();
      test_reset_mid();
      test_back_to_back();
      test_last0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
